// File: rtl/aes_ks_pkg.sv
// Shared types and constants for the AES key-schedule path.
// Used by the round-key buffer and its replay pointer.
package aes_ks_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } ksb_state_e;

    typedef enum logic {
        KSB_FWD = 1'b0,
        KSB_REV = 1'b1
    } ksb_dir_e;

    localparam int AES_MAX_ROUND_KEYS = 15;

endpackage

// File: rtl/ksb_updown_ptr.sv
// Loadable up/down replay pointer with end-of-replay compare.
// The end test comes before any step, so ptr never wraps.
module ksb_updown_ptr
    import aes_ks_pkg::*;
#(
    parameter int PW = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  ksb_dir_e      load_dir,
    input  logic          step,
    input  logic [CW-1:0] count,
    output logic [PW-1:0] ptr,
    output ksb_dir_e      dir,
    output logic          last
);

    logic [CW-1:0] count_m1;

    assign count_m1 = count - CW'(1);
    assign last     = (dir == KSB_REV) ? (ptr == '0) : (CW'(ptr) == count_m1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
            dir <= KSB_FWD;
        end else if (load) begin
            dir <= load_dir;
            ptr <= (load_dir == KSB_REV) ? PW'(count_m1) : '0;
        end else if (step && !last) begin
            ptr <= (dir == KSB_REV) ? ptr - PW'(1) : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/key_schedule_buffer.sv
// Round-key store: loaded once in generation order, replayed forward or
// reverse any number of times until cleared.
module key_schedule_buffer
    import aes_ks_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = AES_MAX_ROUND_KEYS,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             start,
    input  logic             dir,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic [CW-1:0]    count,
    output logic             loaded,
    output ksb_state_e       dbg_state
);

    localparam int PW = $clog2(DEPTH);

    // Both ports use valid/ready: a word transfers on a rising clk edge where
    // valid and ready are both high; the offering side holds its data stable
    // until then, and ready never depends combinationally on valid.

    ksb_state_e       state, state_d;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    wr_idx;
    ksb_dir_e         cur_dir;
    logic             ptr_last;
    logic             wr_en;
    logic             ptr_load;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_ready  = (state == IDLE) || (state == LOAD);
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_valid  = (state == STREAM);
    assign rd_fire   = rd_valid && rd_ready;
    assign rd_last   = rd_valid && ptr_last;
    assign rd_data   = rd_valid ? mem[ptr] : '0;
    assign loaded    = (state == READY);
    assign dbg_state = state;
    assign wr_idx    = (state == IDLE) ? '0 : PW'(count);

    always_comb begin
        state_d  = state;
        count_d  = count;
        wr_en    = 1'b0;
        ptr_load = 1'b0;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    wr_en   = 1'b1;
                    count_d = CW'(1);
                    state_d = wr_last ? READY : LOAD;
                end
            end
            LOAD: begin
                if (wr_fire) begin
                    wr_en   = 1'b1;
                    count_d = count + CW'(1);
                    // Hitting DEPTH without wr_last silently truncates the schedule.
                    if (wr_last || (count_d == CW'(DEPTH))) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (start) begin
                    ptr_load = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (rd_fire && ptr_last) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d  = IDLE;
            count_d  = '0;
            wr_en    = 1'b0;
            ptr_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

    // Clear leaves the array contents alone; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    ksb_updown_ptr #(
        .PW(PW),
        .CW(CW)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .load    (ptr_load),
        .load_dir(ksb_dir_e'(dir)),
        .step    (rd_fire && !clear),
        .count   (count),
        .ptr     (ptr),
        .dir     (cur_dir),
        .last    (ptr_last)
    );

endmodule

// File: tb/tb_key_schedule_buffer.sv
// Directed bench for key_schedule_buffer: a DEPTH=15 instance for load,
// replay, reset and clear, and a DEPTH=4 instance for truncation.
module tb_key_schedule_buffer;
    import aes_ks_pkg::*;

    localparam int W = 128;

    logic clk = 1'b0;
    logic rst;

    // DEPTH = 15 instance
    logic         clear, wr_valid, wr_ready, wr_last, start, dir;
    logic         rd_valid, rd_ready, rd_last, loaded;
    logic [W-1:0] wr_data, rd_data;
    logic [3:0]   count;
    ksb_state_e   st;

    // DEPTH = 4 instance
    logic         b_clear, b_wr_valid, b_wr_ready, b_wr_last, b_start, b_dir;
    logic         b_rd_valid, b_rd_ready, b_rd_last, b_loaded;
    logic [W-1:0] b_wr_data, b_rd_data;
    logic [2:0]   b_count;
    ksb_state_e   b_st;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    key_schedule_buffer #(.WIDTH(W), .DEPTH(15)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last), .start(start), .dir(dir),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .count(count), .loaded(loaded), .dbg_state(st)
    );

    key_schedule_buffer #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .clear(b_clear), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_data(b_wr_data), .wr_last(b_wr_last), .start(b_start), .dir(b_dir),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_last(b_rd_last),
        .count(b_count), .loaded(b_loaded), .dbg_state(b_st)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic begin_replay(input logic d);
        start = 1'b1;
        dir   = d;
        step();
        start = 1'b0;
    endtask

    initial begin
        int exp_idx;
        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        start = 1'b0; dir = 1'b0; rd_ready = 1'b0;
        b_clear = 1'b0; b_wr_valid = 1'b0; b_wr_data = '0; b_wr_last = 1'b0;
        b_start = 1'b0; b_dir = 1'b0; b_rd_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        check("rst_wr_ready", W'(wr_ready), W'(1));
        check("rst_rd_valid", W'(rd_valid), W'(0));
        check("rst_rd_last",  W'(rd_last),  W'(0));
        check("rst_rd_data",  rd_data,      W'(0));
        check("rst_count",    W'(count),    W'(0));
        check("rst_loaded",   W'(loaded),   W'(0));

        // Load 11 words, with a stray start pulse in LOAD that must be ignored.
        for (int i = 0; i <= 10; i++) begin
            start = (i == 5);
            dir   = 1'b1;
            write_word(W'(i), i == 10);
            start = 1'b0;
            if (i == 5) check("start_in_load_state", W'(st), W'(LOAD));
        end
        check("load_count",    W'(count),    W'(11));
        check("load_loaded",   W'(loaded),   W'(1));
        check("load_wr_ready", W'(wr_ready), W'(0));

        // Forward replay, rd_ready tied high; stray start mid-stream.
        rd_ready = 1'b1;
        begin_replay(1'b0);
        check("fwd_loaded_low", W'(loaded), W'(0));
        for (int i = 0; i <= 10; i++) begin
            check("fwd_valid", W'(rd_valid), W'(1));
            check("fwd_data",  rd_data,      W'(i));
            check("fwd_last",  W'(rd_last),  W'(i == 10));
            start = (i == 3);
            dir   = 1'b1;
            step();
            start = 1'b0;
        end
        check("fwd_end_valid",  W'(rd_valid), W'(0));
        check("fwd_end_loaded", W'(loaded),   W'(1));

        // Back-to-back reverse replay with rd_ready toggling 1,0,1,0.
        begin_replay(1'b1);
        exp_idx = 10;
        for (int k = 0; k < 40 && exp_idx >= 0; k++) begin
            rd_ready = (k % 2 == 0);
            #1;
            check("rev_valid", W'(rd_valid), W'(1));
            check("rev_data",  rd_data,      W'(exp_idx));
            check("rev_last",  W'(rd_last),  W'(exp_idx == 0));
            step();
            if (rd_ready) exp_idx--;
        end
        check("rev_all_consumed", W'(exp_idx), W'(-1));
        check("rev_end_state",    W'(st),      W'(READY));

        // Forward again from the same contents.
        rd_ready = 1'b1;
        begin_replay(1'b0);
        for (int i = 0; i <= 10; i++) begin
            check("fwd2_data", rd_data,     W'(i));
            check("fwd2_last", W'(rd_last), W'(i == 10));
            step();
        end

        // Reset in the middle of a replay.
        begin_replay(1'b0);
        step(); step(); step();
        check("pre_rst_data", rd_data, W'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_rd_valid", W'(rd_valid), W'(0));
        check("midrst_count",    W'(count),    W'(0));
        check("midrst_wr_ready", W'(wr_ready), W'(1));
        check("midrst_rd_data",  rd_data,      W'(0));

        // Clear mid-load takes priority over a concurrent write.
        rd_ready = 1'b0;
        write_word(W'(16'h100), 1'b0);
        write_word(W'(16'h101), 1'b0);
        write_word(W'(16'h102), 1'b0);
        check("preclr_count", W'(count), W'(3));
        clear = 1'b1;
        write_word(W'(16'h1ff), 1'b1);
        clear = 1'b0;
        check("clr_count", W'(count), W'(0));
        check("clr_state", W'(st),    W'(IDLE));
        write_word(W'(16'h200), 1'b0);
        write_word(W'(16'h201), 1'b1);
        check("reload_count", W'(count), W'(2));
        rd_ready = 1'b1;
        begin_replay(1'b0);
        check("reload_d0",    rd_data,     W'(16'h200));
        check("reload_last0", W'(rd_last), W'(0));
        step();
        check("reload_d1",    rd_data,     W'(16'h201));
        check("reload_last1", W'(rd_last), W'(1));
        step();

        // Single-word schedule: rd_last on the first word either way.
        clear = 1'b1;
        step();
        clear = 1'b0;
        write_word(W'(8'h55), 1'b1);
        check("one_count", W'(count), W'(1));
        begin_replay(1'b0);
        check("one_fwd_data", rd_data,     W'(8'h55));
        check("one_fwd_last", W'(rd_last), W'(1));
        step();
        begin_replay(1'b1);
        check("one_rev_data", rd_data,     W'(8'h55));
        check("one_rev_last", W'(rd_last), W'(1));
        step();
        check("one_end_state", W'(st), W'(READY));

        // DEPTH=4 truncation: six words offered, only four accepted.
        for (int i = 0; i < 6; i++) begin
            check("trunc_wr_ready", W'(b_wr_ready), W'(i < 4));
            b_wr_valid = 1'b1;
            b_wr_data  = W'(8'h10 + i);
            step();
        end
        b_wr_valid = 1'b0;
        check("trunc_count",  W'(b_count),  W'(4));
        check("trunc_loaded", W'(b_loaded), W'(1));
        b_rd_ready = 1'b1;
        b_start    = 1'b1;
        b_dir      = 1'b1;
        step();
        b_start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            check("trunc_rev_data", b_rd_data,     W'(8'h10 + i));
            check("trunc_rev_last", W'(b_rd_last), W'(i == 0));
            step();
        end
        check("trunc_end_state", W'(b_st), W'(READY));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
